// File: rtl/ic_sram_port.sv
// ic_sram_port: single-cycle SRAM bridge with a one-stage pipeline and 2-entry response FIFO.
module ic_sram_port #(
  parameter logic [31:0] BASE = 32'h2000_0000,
  parameter int AW = 10
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          mem_req,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_addr,
  output logic          mem_gnt,
  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [3:0]    sram_strb,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);
  logic        s1_valid, s1_read, s1_err;
  logic [32:0] fifo [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, inflight;
  logic        in_range, pop, unused;
  assign unused    = ^mem_addr[1:0];
  assign in_range  = mem_addr[31:AW+2] == BASE[31:AW+2];
  assign inflight  = {1'b0, s1_valid} + count;
  assign mem_recv  = !g_reset && count != 2'd0;
  assign pop       = mem_recv && mem_ack;
  // A full pipeline may still accept when the head leaves this same cycle.
  assign mem_gnt   = !g_reset && mem_req && (inflight < 2'd2 || (inflight == 2'd2 && pop));
  assign sram_cen  = mem_gnt && in_range;
  assign sram_wen  = sram_cen && mem_wen;
  assign sram_strb = sram_wen ? mem_strb : 4'b0;
  assign sram_addr = mem_addr[AW+1:2];
  assign sram_wdata = mem_wdata;
  assign mem_rdata = mem_recv ? fifo[rd_ptr][31:0] : 32'b0;
  assign mem_error = mem_recv && fifo[rd_ptr][32];
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      s1_valid <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      s1_valid <= mem_gnt;
      wr_ptr   <= wr_ptr ^ s1_valid;
      rd_ptr   <= rd_ptr ^ pop;
      count    <= count + {1'b0, s1_valid} - {1'b0, pop};
    end
  end
  always_ff @(posedge g_clk) begin
    s1_read <= !mem_wen;
    s1_err  <= !in_range;
    if (s1_valid) fifo[wr_ptr] <= {s1_err, (s1_read && !s1_err) ? sram_rdata : 32'b0};
  end
endmodule

// File: tb/tb_ic_sram_port.sv
// tb_ic_sram_port: scoreboard bench with a word-array reference model and a behavioural SRAM.
module tb_ic_sram_port;
  logic        g_clk, g_reset, mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata, sram_wdata, sram_rdata;
  logic        mem_gnt, mem_recv, mem_error, sram_cen, sram_wen;
  logic [3:0]  sram_strb;
  logic [9:0]  sram_addr;
  ic_sram_port dut (
    .g_clk(g_clk), .g_reset(g_reset), .mem_req(mem_req), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_strb(sram_strb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  int tests = 0, fails = 0, outst = 0, ack_mode = 1;
  logic [32:0] exp_q [$];
  logic [31:0] ref_mem [1024];
  logic [31:0] sram [1024];
  logic        hold;
  logic [32:0] hold_v;
  initial g_clk = 0;
  always #5 g_clk = ~g_clk;
  always @(posedge g_clk)
    if (sram_cen) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++) if (sram_strb[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else sram_rdata <= sram[sram_addr];
    end
  always @(posedge g_clk) begin
    #1;
    mem_ack = (ack_mode == 2) ? 1'($urandom % 2) : (ack_mode == 1);
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic bit in_range(input logic [31:0] a);
    return a[31:12] == 20'h20000;
  endfunction
  function automatic void accept(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m;
    if (!in_range(a)) exp_q.push_back({1'b1, 32'b0});
    else if (w) begin
      m = ref_mem[a[11:2]];
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      ref_mem[a[11:2]] = m;
      exp_q.push_back(33'b0);
    end else exp_q.push_back({1'b0, ref_mem[a[11:2]]});
  endfunction
  always @(negedge g_clk) begin
    if (g_reset) begin
      chk("reset_outputs", {mem_gnt, mem_recv, mem_error, mem_rdata, sram_cen, sram_wen, sram_strb}, 0);
      exp_q.delete();
      outst = 0;
      hold = 0;
    end else begin
      chk("gnt", mem_gnt, mem_req && (outst < 2 || (outst == 2 && mem_recv && mem_ack)));
      chk("sram_cen", sram_cen, mem_req && mem_gnt && in_range(mem_addr));
      if (sram_cen)
        chk("sram_cmd", {sram_wen, sram_strb, sram_addr, sram_wdata},
            {mem_wen, mem_wen ? mem_strb : 4'b0, mem_addr[11:2], mem_wdata});
      if (hold) chk("head_stable", {mem_recv, mem_error, mem_rdata}, {1'b1, hold_v});
      if (mem_recv && mem_ack) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {mem_error, mem_rdata}, 33'h1_dead_dead);
        else chk("rsp", {mem_error, mem_rdata}, exp_q.pop_front());
      end
      hold = mem_recv && !mem_ack;
      hold_v = {mem_error, mem_rdata};
      outst += int'(mem_req && mem_gnt) - int'(mem_recv && mem_ack);
    end
  end
  task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d, output bit g);
    mem_req = 1; mem_wen = w; mem_strb = s; mem_addr = a; mem_wdata = d;
    @(negedge g_clk);
    g = mem_gnt;
    if (g) accept(w, s, a, d);
    @(posedge g_clk); #1;
    mem_req = 0;
  endtask
  task automatic issue_retry(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    bit g = 0;
    for (int k = 0; k < 40 && !g; k++) issue(w, s, a, d, g);
    chk("grant_timeout", g, 1);
  endtask
  task automatic drain();
    for (int k = 0; k < 60 && (outst != 0 || exp_q.size() != 0); k++) @(posedge g_clk);
    @(posedge g_clk); #1;
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge g_clk);
    #1;
  endtask
  initial begin
    bit g;
    int lat, ngr, i;
    for (int k = 0; k < 1024; k++) begin ref_mem[k] = 0; sram[k] = 0; end
    g_reset = 1; mem_req = 0; mem_wen = 0; mem_strb = 0; mem_addr = 0; mem_wdata = 0; mem_ack = 1;
    sram_rdata = 0;
    idle(3);
    g_reset = 0;
    issue(1, 4'hF, 32'h2000_0010, 32'hDEAD_BEEF, g);
    chk("first_accept_after_reset", g, 1);
    drain();
    issue(0, 4'h0, 32'h2000_0010, 32'h0, g);
    chk("read_grant", g, 1);
    lat = 0;
    for (int k = 0; k < 10 && !mem_recv; k++) begin @(negedge g_clk); lat++; end
    chk("read_latency", lat, 2);
    chk("read_data", mem_rdata, 32'hDEAD_BEEF);
    @(posedge g_clk); #1;
    drain();
    issue_retry(1, 4'b0011, 32'h2000_0012, 32'h1234_5678);
    issue_retry(0, 4'h0, 32'h2000_0010, 32'h0);
    chk("merged_model", ref_mem[4], 32'hDEAD_5678);
    issue_retry(0, 4'h0, 32'h3000_0000, 32'h0);
    issue_retry(1, 4'h0, 32'h2000_0010, 32'hFFFF_FFFF);
    issue_retry(0, 4'h0, 32'h2000_0010, 32'h0);
    drain();
    ack_mode = 0;
    idle(1);
    ngr = 0; i = 0;
    for (int k = 0; k < 6; k++) begin
      issue(0, 4'h0, 32'h2000_0000 + 32'(i) * 4, 32'h0, g);
      if (g) begin ngr++; i++; end
    end
    chk("gnt_limit_no_ack", ngr, 2);
    ack_mode = 1;
    while (i < 4) begin issue_retry(0, 4'h0, 32'h2000_0000 + 32'(i) * 4, 32'h0); i++; end
    drain();
    for (int k = 0; k < 8; k++) begin
      ref_mem[32 + k] = 32'(k) * 32'h0101_0101 + 32'h1000;
      sram[32 + k] = ref_mem[32 + k];
    end
    ngr = 0;
    for (int k = 0; k < 8; k++) begin
      issue(0, 4'h0, 32'h2000_0080 + 32'(k) * 4, 32'h0, g);
      if (g) ngr++;
    end
    chk("full_throughput", ngr, 8);
    drain();
    ack_mode = 0;
    idle(1);
    issue_retry(0, 4'h0, 32'h2000_0080, 32'h0);
    issue_retry(0, 4'h0, 32'h2000_0084, 32'h0);
    idle(3);
    g_reset = 1;
    idle(1);
    g_reset = 0;
    @(negedge g_clk);
    chk("recv_after_reset", mem_recv, 0);
    ack_mode = 1;
    idle(5);
    issue_retry(0, 4'h0, 32'h2000_0084, 32'h0);
    drain();
    ack_mode = 2;
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = {($urandom % 8 == 0) ? 20'h30000 : 20'h20000, 12'($urandom % 16) << 2 | 12'($urandom % 4)};
      if ($urandom % 3 == 0) idle(1);
      issue_retry(1'($urandom % 2), 4'($urandom), a, $urandom);
    end
    ack_mode = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
